// File: rtl/numberguess_pkg.sv
// Shared types, constants and guess-conversion helpers for the number-guessing game.
// The BCD helpers are only called when KEYIN_BCD_EN is defined.
package numberguess_pkg;

    localparam int unsigned GUESS_W   = 8;
    localparam int unsigned DIP_W     = 10;
    localparam int unsigned MAX_GUESS = 99;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } keyin_state_t;

    function automatic logic bin_key_ok(input logic [DIP_W-1:0] key);
        return (key <= DIP_W'(MAX_GUESS));
    endfunction

    function automatic logic [GUESS_W-1:0] bin_key_value(input logic [DIP_W-1:0] key);
        return key[GUESS_W-1:0];
    endfunction

    // Two decimal digits in [7:4]/[3:0]; the top switches must be off.
    function automatic logic bcd_key_ok(input logic [DIP_W-1:0] key);
        return (key[9:8] == 2'b00) && (key[7:4] <= 4'd9) && (key[3:0] <= 4'd9);
    endfunction

    function automatic logic [GUESS_W-1:0] bcd_key_value(input logic [DIP_W-1:0] key);
        return GUESS_W'(key[7:4]) * 8'd10 + GUESS_W'(key[3:0]);
    endfunction

endpackage

// File: rtl/keyin_debounce_chk.sv
// Output-protocol checker for keyin_debounce: strobes are exclusive and datain
// only moves together with valid (or under reset).
module keyin_debounce_chk
    import numberguess_pkg::*;
(
    input logic               clk,
    input logic               rst,
    input logic               valid,
    input logic               badkey,
    input logic [GUESS_W-1:0] datain
);

    a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
        !(valid && badkey));

    a_datain_hold: assert property (@(posedge clk) disable iff (rst)
        (!valid && !$past(rst)) |-> (datain == $past(datain)));

endmodule

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser with asynchronous active-high reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keyin_debounce.sv
// Synchronises and debounces the enter key, captures DIP once per debounced press.
// Define KEYIN_BCD_EN to read DIP as two BCD digits instead of a binary value.
module keyin_debounce
    import numberguess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enter,
    input  logic [DIP_W-1:0]   DIP,
    output logic [GUESS_W-1:0] datain,
    output logic               valid,
    output logic               badkey
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic               enter_s;
    logic [DIP_W-1:0]   dip_s;

    keyin_state_t       state_r;
    keyin_state_t       state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               capture_s;
    logic               accept_s;
    logic [GUESS_W-1:0] value_s;

    logic [GUESS_W-1:0] datain_r;
    logic               valid_r;
    logic               badkey_r;

    sync2 #(.W(1)) u_sync_enter (
        .clk (clk),
        .rst (rst),
        .d   (enter),
        .q   (enter_s)
    );

    sync2 #(.W(DIP_W)) u_sync_dip (
        .clk (clk),
        .rst (rst),
        .d   (DIP),
        .q   (dip_s)
    );

    // Debounce FSM next state; the counter restarts on every state change.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (enter_s) begin
                    state_nxt_s = PRESS_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!enter_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = HELD;
                    cnt_nxt_s   = CNT_ZERO;
                    capture_s   = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                cnt_nxt_s = CNT_ZERO;
                if (!enter_s) begin
                    state_nxt_s = RELEASE_WAIT;
                end else begin
                    state_nxt_s = HELD;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back high resumes HELD, so it can never count as a new press.
                if (enter_s) begin
                    state_nxt_s = HELD;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Range check and conversion of the sampled switch value.
    always_comb begin
`ifdef KEYIN_BCD_EN
        accept_s = bcd_key_ok(dip_s);
        value_s  = bcd_key_value(dip_s);
`else
        accept_s = bin_key_ok(dip_s);
        value_s  = bin_key_value(dip_s);
`endif
    end

    // FSM state and debounce counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Registered guess outputs: one strobe per capture, datain held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            datain_r <= {GUESS_W{1'b0}};
            valid_r  <= 1'b0;
            badkey_r <= 1'b0;
        end else begin
            valid_r  <= capture_s && accept_s;
            badkey_r <= capture_s && !accept_s;
            if (capture_s && accept_s) begin
                datain_r <= value_s;
            end else begin
                datain_r <= datain_r;
            end
        end
    end

    assign datain = datain_r;
    assign valid  = valid_r;
    assign badkey = badkey_r;

endmodule

// File: tb/tb_keyin_debounce.sv
// Table-driven, scoreboarded bench for keyin_debounce with DEBOUNCE_CYCLES=4.
module tb_keyin_debounce;
    import numberguess_pkg::*;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    typedef struct {
        logic [9:0] dip;
        int         hold;
        logic       ev;
        logic       eb;
        logic [7:0] ed;
    } vec_t;

    typedef struct {
        logic       v;
        logic       b;
        logic [7:0] d;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enter = 1'b0;
    logic [9:0] DIP = 10'd0;
    logic [7:0] datain;
    logic       valid;
    logic       badkey;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sb[$];
    vec_t tbl[9];

    keyin_debounce #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .enter  (enter),
        .DIP    (DIP),
        .datain (datain),
        .valid  (valid),
        .badkey (badkey)
    );

    keyin_debounce_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .badkey (badkey),
        .datain (datain)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (valid || badkey)) begin
            n_vec = n_vec + 1;
            if (sb.size() == 0) begin
                n_miss = n_miss + 1;
                $display("FAIL strobe_unexpected cyc=%0d valid=%0b badkey=%0b datain=%0d required no strobe",
                         cyc, valid, badkey, datain);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (valid !== e.v || badkey !== e.b || datain !== e.d || cyc != e.c) begin
                    n_miss = n_miss + 1;
                    $display("FAIL strobe got v=%0b b=%0b d=%0d cyc=%0d required v=%0b b=%0b d=%0d cyc=%0d",
                             valid, badkey, datain, cyc, e.v, e.b, e.d, e.c);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_strobe(input logic v, input logic b, input logic [7:0] d, input int rise);
        exp_t e;
        e.v = v; e.b = b; e.d = d; e.c = rise + LAT;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
        n_vec = n_vec + 1;
        if (got !== req) begin
            n_miss = n_miss + 1;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    // One press: DIP settles, enter held for 'hold' cycles; DIP is scrambled mid-hold.
    task automatic press(input vec_t t);
        DIP = t.dip;
        wait_cyc(3);
        enter = 1'b1;
        if (t.ev || t.eb) expect_strobe(t.ev, t.eb, t.ed, cyc);
        for (int i = 0; i < t.hold; i++) begin
            wait_cyc(1);
            if (i == 9) DIP = ~t.dip;
        end
        enter = 1'b0;
        wait_cyc(12);
    endtask

    initial begin
        logic [9:0] dip_a, dip_b, dip_c, dip_d;
        logic [7:0] val_a, val_b, val_c;
`ifdef KEYIN_BCD_EN
        tbl[0] = '{10'h045, 20, 1'b1, 1'b0, 8'd45};
        tbl[1] = '{10'h037,  3, 1'b0, 1'b0, 8'd45};
        tbl[2] = '{10'h04A, 20, 1'b0, 1'b1, 8'd45};
        tbl[3] = '{10'h145,  5, 1'b0, 1'b1, 8'd45};
        tbl[4] = '{10'h099,  4, 1'b0, 1'b0, 8'd45};
        tbl[5] = '{10'h099,  6, 1'b1, 1'b0, 8'd99};
        tbl[6] = '{10'h0A0,  8, 1'b0, 1'b1, 8'd99};
        tbl[7] = '{10'h000, 12, 1'b1, 1'b0, 8'd0};
        tbl[8] = '{10'h037, 20, 1'b1, 1'b0, 8'd37};
        dip_a = 10'h012; val_a = 8'd12;
        dip_b = 10'h064; val_b = 8'd64;
        dip_c = 10'h077; val_c = 8'd77;
        dip_d = 10'h005;
`else
        tbl[0] = '{10'd37,   20, 1'b1, 1'b0, 8'd37};
        tbl[1] = '{10'd55,    3, 1'b0, 1'b0, 8'd37};
        tbl[2] = '{10'd150,  20, 1'b0, 1'b1, 8'd37};
        tbl[3] = '{10'd99,    5, 1'b1, 1'b0, 8'd99};
        tbl[4] = '{10'd20,    4, 1'b0, 1'b0, 8'd99};
        tbl[5] = '{10'd100,   6, 1'b0, 1'b1, 8'd99};
        tbl[6] = '{10'd0,     8, 1'b1, 1'b0, 8'd0};
        tbl[7] = '{10'd1023, 12, 1'b0, 1'b1, 8'd0};
        tbl[8] = '{10'd37,   20, 1'b1, 1'b0, 8'd37};
        dip_a = 10'd18; val_a = 8'd18;
        dip_b = 10'd64; val_b = 8'd64;
        dip_c = 10'd77; val_c = 8'd77;
        dip_d = 10'd5;
`endif

        // Reset state.
        wait_cyc(2);
        check("reset_datain", datain, 8'd0);
        check("reset_strobes", {6'd0, valid, badkey}, 8'd0);
        rst = 1'b0;
        wait_cyc(4);

        for (int i = 0; i < 9; i++) begin
            press(tbl[i]);
            check($sformatf("hold_datain_%0d", i), datain, tbl[i].ed);
        end

        // Release bounce 0/1/0, then re-press 4 cycles after the final fall: absorbed.
        DIP = dip_a;
        wait_cyc(3);
        enter = 1'b1;
        expect_strobe(1'b1, 1'b0, val_a, cyc);
        wait_cyc(15);
        enter = 1'b0; wait_cyc(1);
        enter = 1'b1; wait_cyc(1);
        enter = 1'b0; wait_cyc(4);
        enter = 1'b1;
        DIP = dip_b;
        wait_cyc(10);
        // Clean release; re-press 5 cycles later lands in IDLE and is a new press.
        enter = 1'b0; wait_cyc(5);
        enter = 1'b1;
        expect_strobe(1'b1, 1'b0, val_b, cyc);
        wait_cyc(15);
        enter = 1'b0;
        wait_cyc(12);
        check("bounce_datain", datain, val_b);

        // Reset during PRESS_WAIT: press discarded, datain cleared immediately.
        DIP = dip_c;
        wait_cyc(3);
        enter = 1'b1;
        wait_cyc(5);
        rst = 1'b1;
        #1;
        check("midpress_rst_datain", datain, 8'd0);
        enter = 1'b0;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(12);
        check("after_rst_datain", datain, 8'd0);
        press('{dip_d, 10, 1'b1, 1'b0, 8'd5});
        check("post_rst_press", datain, 8'd5);

        // Enter already high when reset deasserts counts as a fresh press.
        DIP = dip_c;
        enter = 1'b1;
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        expect_strobe(1'b1, 1'b0, val_c, cyc);
        wait_cyc(15);
        enter = 1'b0;
        wait_cyc(12);
        check("enter_at_reset", datain, val_c);

        n_vec = n_vec + 1;
        if (sb.size() != 0) begin
            n_miss = n_miss + 1;
            $display("FAIL missing_strobes got %0d outstanding required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
